// File: rtl/demux16_collect_pkg.sv
// Shared encodings and defaults for the 1-to-16 serial-bit capture block,
// plus the 2-to-4 gate-level decoder used as the leaf of its one-hot tree.
package demux16_collect_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int SEL_W_DEF = 4;

    localparam logic MODE_SEQ  = 1'b0;
    localparam logic MODE_ADDR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_COLLECT = 2'b01,
        ST_HOLD    = 2'b10
    } state_t;

    // a[0] is the MSB; result index 0 corresponds to a == 2'b00
    function automatic logic [0:3] dec2to4(input logic [0:1] a, input logic en);
        dec2to4 = {en & ~a[0] & ~a[1],
                   en & ~a[0] &  a[1],
                   en &  a[0] & ~a[1],
                   en &  a[0] &  a[1]};
    endfunction

endpackage

// File: rtl/demux16_onehot.sv
// Combinational 4-to-16 one-hot decoder (zero latency, no handshake), built as a
// tree of five 2-to-4 decoders: one on sel[0:1] enabling four leaves on sel[2:3].
module demux16_onehot
    import demux16_collect_pkg::*;
(
    input  logic [0:3]  sel,
    input  logic        en,
    output logic [0:15] onehot
);

    logic [0:3] grp;

    assign grp = dec2to4(sel[0:1], en);

    for (genvar g = 0; g < 4; g++) begin : g_leaf
        assign onehot[4*g +: 4] = dec2to4(sel[2:3], grp[g]);
    end

endmodule

// File: rtl/demux16_collect.sv
// Routes serial bits into addressed word positions; word valid 1 cycle after the 16th
// distinct write. in_ready only in COLLECT; completed word held until out_ack.
module demux16_collect
    import demux16_collect_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int SEL_W = SEL_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic [0:SEL_W-1] sel,
    output logic             in_ready,
    output logic [0:WIDTH-1] out,
    output logic [0:WIDTH-1] wr_mask,
    output logic             out_valid,
    input  logic             out_ack,
    output logic             busy
);

    state_t           state;
    state_t           state_nx;
    logic [0:SEL_W-1] cnt;
    logic [0:SEL_W-1] idx;
    logic             mode_q;
    logic             accept;
    logic             load;
    logic             done;
    logic [0:WIDTH-1] we;
    logic [0:WIDTH-1] mask_nx;

    // start wins over a simultaneous bit, which is dropped
    assign accept  = (state == ST_COLLECT) & in_valid & ~start;
    assign idx     = (mode_q == MODE_ADDR) ? sel : cnt;
    assign mask_nx = wr_mask | we;
    assign done    = accept & (&mask_nx);
    assign load    = start & ((state == ST_IDLE) | (state == ST_COLLECT) |
                              ((state == ST_HOLD) & out_ack));

    demux16_onehot u_onehot (
        .sel    (idx),
        .en     (accept),
        .onehot (we)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:    if (start) state_nx = ST_COLLECT;
            ST_COLLECT: if (!start && done) state_nx = ST_HOLD;
            ST_HOLD:    if (out_ack) state_nx = start ? ST_COLLECT : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_COLLECT);
        out_valid = (state == ST_HOLD);
        busy      = (state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            wr_mask <= '0;
            cnt     <= '0;
            mode_q  <= MODE_SEQ;
        end else if (load) begin
            out     <= '0;
            wr_mask <= '0;
            cnt     <= '0;
            mode_q  <= mode;
        end else if (accept) begin
            out     <= (out & ~we) | (we & {WIDTH{in_bit}});
            wr_mask <= mask_nx;
            if (mode_q == MODE_SEQ) begin
                cnt <= cnt + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_demux16_collect.sv
// Scoreboarded bench for demux16_collect: directed scenarios plus random traffic
// against a position/count reference model.
module tb_demux16_collect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_bit = 1'b0;
    logic [0:3]  sel = '0;
    logic        out_ack = 1'b0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [0:15] out_w;
    logic [0:15] mask_w;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    demux16_collect dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .sel       (sel),
        .in_ready  (in_ready),
        .out       (out_w),
        .wr_mask   (mask_w),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .busy      (busy)
    );

    // Reference model: phase 0 idle, 1 collecting, 2 holding a finished word
    int          m_st   = 0;
    logic [0:15] m_word = '0;
    logic [0:15] m_wr   = '0;
    int          m_n    = 0;
    bit          m_mode = 1'b0;

    typedef struct {
        logic [0:15] w;
        int          c;
    } exp_t;
    exp_t sb_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic m_clear(input bit md);
        m_word = '0;
        m_wr   = '0;
        m_n    = 0;
        m_mode = md;
    endtask

    task automatic m_update(input bit s, input bit md, input bit v, input bit b,
                            input logic [3:0] sl, input bit ak);
        int idx;
        case (m_st)
            0: if (s) begin
                m_clear(md);
                m_st = 1;
            end
            1: if (s) begin
                m_clear(md);
            end else if (v) begin
                idx = m_mode ? int'(sl) : (m_n % 16);
                m_word[idx] = b;
                m_wr[idx]   = 1'b1;
                m_n++;
                if (m_wr == 16'hFFFF) begin
                    m_st = 2;
                    sb_q.push_back('{w: m_word, c: cyc});
                end
            end
            2: if (ak) begin
                if (s) begin
                    m_clear(md);
                    m_st = 1;
                end else begin
                    m_st = 0;
                end
            end
            default: m_st = 0;
        endcase
    endtask

    // Inputs are applied 1 time unit after a rising edge and held for one cycle
    task automatic step(input bit s, input bit md, input bit v, input bit b,
                        input logic [3:0] sl, input bit ak);
        start    = s;
        mode     = md;
        in_valid = v;
        in_bit   = b;
        sel      = sl;
        out_ack  = ak;
        @(posedge clk);
        #1;
        m_update(s, md, v, b, sl, ak);
        start    = 1'b0;
        in_valid = 1'b0;
        out_ack  = 1'b0;
    endtask

    // Monitor: per-cycle state/data check and scoreboard pop when a word appears
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        chk("in_ready", in_ready, m_st == 1);
        chk("out_valid", out_valid, m_st == 2);
        chk("busy", busy, m_st != 0);
        chk("out", out_w, m_word);
        chk("wr_mask", mask_w, m_wr);
        if (out_valid && !prev_ov) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: out_valid rose at cycle %0d with no word expected", cyc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_word", out_w, e.w);
                chk("sb_latency_cycle", cyc, e.c);
            end
        end
        prev_ov = out_valid;
    end

    initial begin
        logic [0:15] pat;
        int          others;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", out_w, 16'h0000);
        chk("rst_mask", mask_w, 16'h0000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Sequential mode, bits 1,0,...,0,1
        step(1, 0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 16; i++) step(0, 0, 1, (i == 0 || i == 15), 4'd0, 0);
        chk("seq_valid", out_valid, 1'b1);
        chk("seq_word", out_w, 16'h8001);
        step(0, 0, 0, 0, 4'd0, 1);
        chk("seq_acked_busy", busy, 1'b0);

        // Addressed mode, walking sel 0..15
        step(1, 1, 0, 0, 4'd0, 0);
        for (int k = 0; k < 16; k++) step(0, 0, 1, 1, 4'(k), 0);
        chk("walk_mask", mask_w, 16'hFFFF);
        chk("walk_valid", out_valid, 1'b1);
        step(0, 0, 0, 0, 4'd0, 1);

        // Addressed mode, repeat write to position 5
        step(1, 1, 0, 0, 4'd0, 0);
        step(0, 0, 1, 1, 4'd5, 0);
        step(0, 0, 1, 0, 4'd5, 0);
        others = 0;
        for (int k = 0; k < 16; k++) begin
            if (k != 5) begin
                step(0, 0, 1, 1, 4'(k), 0);
                others++;
                if (others == 14) chk("rep_not_done", out_valid, 1'b0);
            end
        end
        chk("rep_done", out_valid, 1'b1);
        chk("rep_bit5", out_w[5], 1'b0);

        // HOLD ignores bits and a lone start; ack+start restarts without bubble
        for (int i = 0; i < 4; i++) step(i[0], 1, 1, 1'($urandom), 4'($urandom), 0);
        chk("hold_word", out_w, 16'hFBFF);
        chk("hold_valid", out_valid, 1'b1);
        step(1, 0, 0, 0, 4'd0, 1);
        chk("ackstart_busy", busy, 1'b1);
        chk("ackstart_ready", in_ready, 1'b1);
        chk("ackstart_out", out_w, 16'h0000);
        chk("ackstart_mask", mask_w, 16'h0000);

        // Sequential mode with a 3-cycle in_valid gap after 8 bits
        pat = 16'hA5C3;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) repeat (3) step(0, 0, 0, 1'($urandom), 4'($urandom), 0);
            step(0, 0, 1, pat[i], 4'($urandom), 0);
        end
        chk("gap_word", out_w, 16'hA5C3);
        step(0, 0, 0, 0, 4'd0, 1);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 59) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
                 1'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
        end
        step(0, 0, 0, 0, 4'd0, 1);

        // Asynchronous reset after 8 accepts
        step(1, 0, 0, 0, 4'd0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 1, 4'd0, 0);
        chk("pre_rst_busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        m_st = 0;
        m_clear(1'b0);
        #1;
        chk("arst_out", out_w, 16'h0000);
        chk("arst_mask", mask_w, 16'h0000);
        chk("arst_valid", out_valid, 1'b0);
        chk("arst_busy", busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step(0, 0, 0, 0, 4'd0, 0);
        step(0, 0, 0, 0, 4'd0, 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
